// File: rtl/irq_request_ctrl.sv
// Multi-channel IRQ request controller: synchronises external lines, tracks edge/level
// pending state, and issues one prioritised, acknowledged, EOI-terminated request at a time.
module irq_request_ctrl #(
  parameter int N_CH = 8,
  parameter int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N_CH-1:0] EX_irq,
  input  logic [N_CH-1:0] edge_mode,
  input  logic [N_CH-1:0] mask_en,
  input  logic            CPSR_7,
  input  logic            INTA_irq,
  input  logic            EOI,
  output logic            INT_irq,
  output logic [ID_W-1:0] INT_id,
  output logic [N_CH-1:0] pending,
  output logic            in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state;
  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] s2_d;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] ack_clear;
  logic [N_CH-1:0] pending_next;
  logic [ID_W-1:0] winner;
  logic            any_eligible;
  logic            ack;

  assign rise         = s2 & ~s2_d;
  assign eligible     = pending & mask_en;
  assign any_eligible = |eligible;
  assign ack          = (state == REQ) && INTA_irq;

  // Only an edge channel loses its pending bit on acknowledge; a new edge in the same cycle wins.
  always_comb begin
    ack_clear = '0;
    if (ack) ack_clear[INT_id] = edge_mode[INT_id];
  end

  assign pending_next = (edge_mode & (rise | (pending & ~ack_clear))) | (~edge_mode & s2);

  always_comb begin
    winner = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1      <= '0;
      s2      <= '0;
      s2_d    <= '0;
      pending <= '0;
    end else begin
      s1      <= EX_irq;
      s2      <= s1;
      s2_d    <= s2;
      pending <= pending_next;
    end
  end

  // INT_id is frozen once a request is raised; no preemption until EOI returns to IDLE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      INT_irq    <= 1'b0;
      INT_id     <= '0;
      in_service <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!CPSR_7 && any_eligible) begin
            state   <= REQ;
            INT_irq <= 1'b1;
            INT_id  <= winner;
          end
        end
        REQ: begin
          if (INTA_irq) begin
            state      <= SERVICE;
            INT_irq    <= 1'b0;
            in_service <= 1'b1;
          end else if (CPSR_7 || !eligible[INT_id]) begin
            state   <= IDLE;
            INT_irq <= 1'b0;
          end
        end
        SERVICE: begin
          if (EOI) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          INT_irq <= 1'b0;
        end
      endcase
    end
  end

endmodule
